// File: rtl/fm_tx_ctrl_pkg.sv
// Shared definitions for the FM transmit sequencer: state encoding, widths,
// default carrier and the sample-to-tuning-word conversion.
package fm_tx_ctrl_pkg;

    localparam int unsigned TUNE_W   = 32;
    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned PTR_W    = 2;
    localparam int unsigned CNT_W    = 3;

    // Carrier shared with the fm_tx NCO: 100 MHz at 192 MHz, 32-bit accumulator.
    localparam logic [TUNE_W-1:0] DEFAULT_CARRIER = 32'h85555555;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } tx_state_e;

    // Carrier plus the sign-extended sample scaled by 2^shift, wrapping mod 2^32.
    function automatic logic [TUNE_W-1:0] tune_word(input logic [TUNE_W-1:0]   carrier,
                                                    input logic [SAMPLE_W-1:0] sample,
                                                    input int unsigned         shift);
        logic [TUNE_W-1:0] ext;
        ext = {{(TUNE_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
        return carrier + (ext << shift);
    endfunction

endpackage

// File: rtl/fm_tx_ctrl_fifo.sv
// 4x8 synchronous sample FIFO with flush; the head entry is read combinationally.
module fm_fifo
    import fm_tx_ctrl_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_nrst,
    input  logic                i_push,
    input  logic                i_pop,
    input  logic                i_flush,
    input  logic [SAMPLE_W-1:0] i_wdata,
    output logic [SAMPLE_W-1:0] o_rdata,
    output logic [CNT_W-1:0]    o_count,
    output logic                o_full,
    output logic                o_empty
);

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                do_push;
    logic                do_pop;

    // A flush discards everything, including a push in the same cycle.
    assign do_push = i_push && !o_full  && !i_flush;
    assign do_pop  = i_pop  && !o_empty && !i_flush;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      cnt_q <= cnt_q + CNT_W'(1);
            else if (!do_push && do_pop) cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr_q] <= i_wdata;
    end

    assign o_rdata = mem[rd_ptr_q];
    assign o_count = cnt_q;
    assign o_full  = (cnt_q == CNT_W'(DEPTH));
    assign o_empty = (cnt_q == '0);

endmodule

// File: rtl/fm_tx_ctrl.sv
// FM transmit sample scheduler: buffers audio samples, emits one NCO tuning
// word per sample tick, and sequences carrier enable, priming and underruns.
module fm_tx_ctrl
    import fm_tx_ctrl_pkg::*;
#(
    parameter logic [TUNE_W-1:0] p_carrier  = DEFAULT_CARRIER,
    parameter int unsigned       p_dev_shift = 12,
    parameter int unsigned       p_rate_div  = 4000,
    parameter int unsigned       p_prime     = 2,
    parameter int unsigned       p_urun_max  = 16
) (
    input  logic                i_clk,
    input  logic                i_nrst,
    input  logic                i_en,
    input  logic [SAMPLE_W-1:0] i_data,
    input  logic                i_valid,
    output logic                o_ready,
    output logic [TUNE_W-1:0]   o_tune,
    output logic                o_tune_vld,
    output logic                o_on,
    output logic                o_urun,
    input  logic                i_clr
);

    localparam int unsigned DIV_W  = $clog2(p_rate_div);
    localparam int unsigned URUN_W = $clog2(p_urun_max + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(p_rate_div - 1);
    localparam logic [URUN_W-1:0] URUN_LAST = URUN_W'(p_urun_max - 1);
    localparam logic [CNT_W-1:0]  PRIME_CNT = CNT_W'(p_prime);

    tx_state_e           state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [URUN_W-1:0]   ucnt_q, ucnt_d;
    logic [TUNE_W-1:0]   tune_q, tune_d;
    logic                vld_q, vld_d;
    logic                on_q;
    logic                urun_q, urun_d;
    logic                tick;
    logic                pop;
    logic                flush;

    logic [SAMPLE_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    fm_fifo u_fifo (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_push  (i_valid),
        .i_pop   (pop),
        .i_flush (flush),
        .i_wdata (i_data),
        .o_rdata (fifo_rdata),
        .o_count (fifo_count),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_ready = !fifo_full;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            ucnt_q  <= '0;
            tune_q  <= p_carrier;
            vld_q   <= 1'b0;
            on_q    <= 1'b0;
            urun_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            ucnt_q  <= ucnt_d;
            tune_q  <= tune_d;
            vld_q   <= vld_d;
            on_q    <= (state_d == ST_RUN);
            urun_q  <= urun_d;
        end
    end

    // Next state, divider, underrun tracking and tuning-word selection.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        ucnt_d  = ucnt_q;
        tune_d  = tune_q;
        vld_d   = 1'b0;
        urun_d  = urun_q;
        pop     = 1'b0;
        flush   = 1'b0;
        tick    = (state_q == ST_RUN) && (div_q == DIV_LAST);

        if (i_clr) urun_d = 1'b0;
        if (state_q != ST_IDLE) div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

        if (!i_en) begin
            // Disable wins over a coincident tick; samples already queued are dropped.
            state_d = ST_IDLE;
            div_d   = '0;
            ucnt_d  = '0;
            tune_d  = p_carrier;
            flush   = (state_q != ST_IDLE);
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_PRIME;
                    div_d   = '0;
                end
                ST_PRIME: begin
                    if (fifo_count >= PRIME_CNT) begin
                        state_d = ST_RUN;
                        div_d   = '0;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        vld_d = 1'b1;
                        if (!fifo_empty) begin
                            pop    = 1'b1;
                            tune_d = tune_word(p_carrier, fifo_rdata, p_dev_shift);
                            ucnt_d = '0;
                        end else begin
                            tune_d = p_carrier;
                            urun_d = 1'b1;
                            if (ucnt_q == URUN_LAST) begin
                                state_d = ST_PRIME;
                                div_d   = '0;
                                ucnt_d  = '0;
                            end else begin
                                ucnt_d = ucnt_q + URUN_W'(1);
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign o_tune     = tune_q;
    assign o_tune_vld = vld_q;
    assign o_on       = on_q;
    assign o_urun     = urun_q;

endmodule
